// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } mem_state_e;

    localparam int MEM_WORD_WIDTH_DEF = 32;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with a registered read port; contents are not reset.
module mem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Memory target for the control unit's mem_rd/mem_wr strobes: wait states, then a four-phase response.
// state    | meaning
// MEM_IDLE | waiting for a request
// MEM_BUSY | counting wait states
// MEM_RESP | first cycle commits and raises mem_rdy; then hold until request drops
module mem_responder
    import mem_pkg::*;
#(
    parameter int WORD_WIDTH  = MEM_WORD_WIDTH_DEF,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_rd,
    input  logic                  mem_wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    output logic [WORD_WIDTH-1:0] rd_data,
    output logic                  mem_rdy,
    output logic                  mem_err
);

    localparam int CW     = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    mem_state_e            r_state;
    mem_state_e            w_next;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic                  r_op_rd;
    logic                  r_op_wr;
    logic                  r_rdy;
    logic                  r_err;
    logic [WORD_WIDTH-1:0] r_rd_data;

    logic                  w_accept;
    logic                  w_complete;
    logic                  w_release;
    logic                  w_we;
    logic                  w_err;
    logic [RAM_AW-1:0]     w_ram_addr;
    logic [WORD_WIDTH-1:0] w_ram_rdata;

    assign w_err = (r_op_rd & r_op_wr) | ({1'b0, r_addr} >= DEPTH_L);

    // In IDLE the RAM already looks at the live address so a zero-wait read has its data one edge later.
    assign w_ram_addr = (r_state == MEM_IDLE) ? addr[RAM_AW-1:0] : r_addr[RAM_AW-1:0];

    mem_array #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH),
        .AW    (RAM_AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MEM_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_complete = 1'b0;
        w_release  = 1'b0;
        w_we       = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                if (mem_rd || mem_wr) begin
                    w_accept = 1'b1;
                    w_next   = (WAIT_CYCLES > 0) ? MEM_BUSY : MEM_RESP;
                end
            end
            MEM_BUSY: begin
                if (r_cnt == '0) begin
                    w_next = MEM_RESP;
                end
            end
            MEM_RESP: begin
                if (!r_rdy) begin
                    w_complete = 1'b1;
                    w_we       = r_op_wr & ~w_err;
                end else if (!mem_rd && !mem_wr) begin
                    w_release = 1'b1;
                    w_next    = MEM_IDLE;
                end
            end
            default: w_next = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_op_rd   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wr_data;
                r_op_rd <= mem_rd;
                r_op_wr <= mem_wr;
                r_cnt   <= CNT_LOAD;
            end else if (r_state == MEM_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_complete) begin
                r_rdy <= 1'b1;
                r_err <= w_err;
                if (w_err) begin
                    r_rd_data <= '0;
                end else if (!r_op_wr) begin
                    r_rd_data <= w_ram_rdata;
                end
            end
            if (w_release) begin
                r_rdy <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    assign rd_data = r_rd_data;
    assign mem_rdy = r_rdy;
    assign mem_err = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: three responders (0, 2, 3 wait states) against a word-level memory model.
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        tb_rd    [3];
    logic        tb_wr    [3];
    logic [15:0] tb_addr  [3];
    logic [31:0] tb_wdata [3];
    logic [31:0] o_rdata  [3];
    logic        o_rdy    [3];
    logic        o_err    [3];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [3][1024];
    bit          m_kn  [3][1024];
    logic [31:0] m_rd  [3];

    mem_responder #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_rd(tb_rd[0]), .mem_wr(tb_wr[0]), .addr(tb_addr[0]),
        .wr_data(tb_wdata[0]), .rd_data(o_rdata[0]), .mem_rdy(o_rdy[0]), .mem_err(o_err[0]));
    mem_responder #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_rd(tb_rd[1]), .mem_wr(tb_wr[1]), .addr(tb_addr[1]),
        .wr_data(tb_wdata[1]), .rd_data(o_rdata[1]), .mem_rdy(o_rdy[1]), .mem_err(o_err[1]));
    mem_responder #(.WORD_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(1024), .WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem_rd(tb_rd[2]), .mem_wr(tb_wr[2]), .addr(tb_addr[2]),
        .wr_data(tb_wdata[2]), .rd_data(o_rdata[2]), .mem_rdy(o_rdy[2]), .mem_err(o_err[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    // Word-level reference: errors return 0, writes leave the last read word in place.
    task automatic model_op(input int d, input bit rd, input bit wr, input logic [15:0] a,
                            input logic [31:0] wd, output logic exp_err,
                            output logic [31:0] exp_data, output bit known);
        exp_err = (rd && wr) || (a >= 16'd1024);
        if (exp_err) begin
            m_rd[d]  = 32'h0;
            exp_data = 32'h0;
            known    = 1'b1;
        end else if (wr) begin
            m_mem[d][int'(a)] = wd;
            m_kn[d][int'(a)]  = 1'b1;
            exp_data = m_rd[d];
            known    = (m_rd[d] !== 32'hx);
        end else begin
            known    = m_kn[d][int'(a)];
            exp_data = m_mem[d][int'(a)];
            m_rd[d]  = known ? exp_data : 32'hx;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_rd[i] = 32'h0;
    endtask

    // Drives one full handshake; addr/wr_data are scrambled every cycle after acceptance.
    task automatic bus_op(input int d, input bit rd, input bit wr, input logic [15:0] a,
                          input logic [31:0] wd, input int hold, output int lat,
                          output logic [31:0] data, output logic err, output bit timeout,
                          output bit stable, output logic rdy_after);
        int n;
        @(negedge clk);
        tb_rd[d] = rd; tb_wr[d] = wr; tb_addr[d] = a; tb_wdata[d] = wd;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            tb_addr[d]  = 16'($urandom);
            tb_wdata[d] = $urandom;
        end while (!o_rdy[d] && n < 20);
        timeout = (o_rdy[d] !== 1'b1);
        lat  = n - 1;
        data = o_rdata[d];
        err  = o_err[d];
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (o_rdy[d] !== 1'b1 || o_rdata[d] !== data || o_err[d] !== err) stable = 1'b0;
        end
        @(negedge clk);
        tb_rd[d] = 1'b0; tb_wr[d] = 1'b0;
        @(posedge clk); #1;
        rdy_after = o_rdy[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (o_rdy[d] !== 1'b0 || o_err[d] !== 1'b0 || o_rdata[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_values dut%0d: rdy=%b err=%b rd_data=%h, want 0/0/0",
                         d, o_rdy[d], o_err[d], o_rdata[d]);
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(1, 0, 1, 16'h0010, 32'hDEADBEEF, 0, lat, data, err, to, st, ra);
        model_op(1, 0, 1, 16'h0010, 32'hDEADBEEF, ee, ed, kn);
        checks++;
        if (to || lat != 3 || err !== 1'b0) begin
            failures++;
            $display("FAIL w2_write: timeout=%0d latency=%0d err=%b, want 0/3/0", to, lat, err);
        end
        bus_op(1, 1, 0, 16'h0010, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'h0010, 32'h0, ee, ed, kn);
        checks++;
        if (to || data !== 32'hDEADBEEF || err !== 1'b0 || ra !== 1'b0) begin
            failures++;
            $display("FAIL w2_readback: rd_data=%h err=%b rdy_after=%b, want deadbeef/0/0", data, err, ra);
        end
    endtask

    task automatic test_hold_stable();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(0, 0, 1, 16'h0005, 32'h12345678, 0, lat, data, err, to, st, ra);
        model_op(0, 0, 1, 16'h0005, 32'h12345678, ee, ed, kn);
        checks++;
        if (to || lat != 1) begin
            failures++;
            $display("FAIL w0_write_latency: latency=%0d timeout=%0d, want 1", lat, to);
        end
        bus_op(0, 1, 0, 16'h0005, 32'h0, 4, lat, data, err, to, st, ra);
        model_op(0, 1, 0, 16'h0005, 32'h0, ee, ed, kn);
        checks++;
        if (to || lat != 1 || data !== 32'h12345678) begin
            failures++;
            $display("FAIL w0_read: latency=%0d rd_data=%h, want 1/12345678", lat, data);
        end
        checks++;
        if (!st || ra !== 1'b0) begin
            failures++;
            $display("FAIL w0_hold_release: stable=%0d rdy_after_release=%b, want 1/0", st, ra);
        end
    endtask

    task automatic test_both_high();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(1, 0, 1, 16'h0003, 32'hA5A50303, 0, lat, data, err, to, st, ra);
        model_op(1, 0, 1, 16'h0003, 32'hA5A50303, ee, ed, kn);
        bus_op(1, 1, 1, 16'h0003, 32'h99999999, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 1, 16'h0003, 32'h99999999, ee, ed, kn);
        checks++;
        if (to || err !== 1'b1 || data !== 32'h0 || lat != 3) begin
            failures++;
            $display("FAIL both_high: err=%b rd_data=%h latency=%0d, want 1/00000000/3", err, data, lat);
        end
        bus_op(1, 1, 0, 16'h0003, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'h0003, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'hA5A50303 || err !== 1'b0) begin
            failures++;
            $display("FAIL both_high_nowrite: rd_data=%h err=%b, want a5a50303/0", data, err);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(1, 0, 1, 16'h0000, 32'h0BADF00D, 0, lat, data, err, to, st, ra);
        model_op(1, 0, 1, 16'h0000, 32'h0BADF00D, ee, ed, kn);
        bus_op(1, 0, 1, 16'd1024, 32'h77777777, 0, lat, data, err, to, st, ra);
        model_op(1, 0, 1, 16'd1024, 32'h77777777, ee, ed, kn);
        checks++;
        if (err !== 1'b1 || data !== 32'h0) begin
            failures++;
            $display("FAIL oor_write: err=%b rd_data=%h, want 1/00000000", err, data);
        end
        bus_op(1, 1, 0, 16'd1024, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'd1024, 32'h0, ee, ed, kn);
        checks++;
        if (err !== 1'b1 || data !== 32'h0) begin
            failures++;
            $display("FAIL oor_read: err=%b rd_data=%h, want 1/00000000", err, data);
        end
        bus_op(1, 1, 0, 16'h0000, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'h0000, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'h0BADF00D || err !== 1'b0) begin
            failures++;
            $display("FAIL oor_no_alias: addr0=%h err=%b, want 0badf00d/0", data, err);
        end
    endtask

    task automatic test_busy_change();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(1, 0, 1, 16'h0040, 32'h40404040, 0, lat, data, err, to, st, ra);
        model_op(1, 0, 1, 16'h0040, 32'h40404040, ee, ed, kn);
        bus_op(1, 1, 0, 16'h0040, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'h0040, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'h40404040) begin
            failures++;
            $display("FAIL busy_change: addr40=%h, want 40404040", data);
        end
    endtask

    task automatic test_early_drop();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        int hi_cnt, first_hi;
        @(negedge clk);
        tb_wr[1] = 1'b1; tb_addr[1] = 16'h0050; tb_wdata[1] = 32'h50505050;
        @(posedge clk); #1;
        tb_wr[1] = 1'b0; tb_addr[1] = 16'h0051;
        model_op(1, 0, 1, 16'h0050, 32'h50505050, ee, ed, kn);
        hi_cnt = 0; first_hi = -1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (o_rdy[1] === 1'b1) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
        end
        checks++;
        if (hi_cnt != 1 || first_hi != 3) begin
            failures++;
            $display("FAIL early_drop_pulse: high_cycles=%0d first=%0d, want 1/3", hi_cnt, first_hi);
        end
        bus_op(1, 1, 0, 16'h0050, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(1, 1, 0, 16'h0050, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'h50505050) begin
            failures++;
            $display("FAIL early_drop_commit: addr50=%h, want 50505050", data);
        end
    endtask

    task automatic test_reset_busy();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        bus_op(2, 0, 1, 16'h0020, 32'h11112222, 0, lat, data, err, to, st, ra);
        model_op(2, 0, 1, 16'h0020, 32'h11112222, ee, ed, kn);
        @(negedge clk);
        tb_wr[2] = 1'b1; tb_addr[2] = 16'h0020; tb_wdata[2] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_rdy[2] !== 1'b0 || o_err[2] !== 1'b0 || o_rdata[2] !== 32'h0) begin
            failures++;
            $display("FAIL reset_busy_outputs: rdy=%b err=%b rd_data=%h, want 0/0/0",
                     o_rdy[2], o_err[2], o_rdata[2]);
        end
        @(negedge clk);
        tb_wr[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus_op(2, 1, 0, 16'h0020, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(2, 1, 0, 16'h0020, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'h11112222) begin
            failures++;
            $display("FAIL reset_busy_nocommit: addr20=%h, want 11112222", data);
        end
    endtask

    task automatic test_reset_resp();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        int n;
        logic rdy_before;
        @(negedge clk);
        tb_wr[2] = 1'b1; tb_addr[2] = 16'h0020; tb_wdata[2] = 32'hABCD0123;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!o_rdy[2] && n < 20);
        rdy_before = o_rdy[2];
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rdy_before !== 1'b1 || o_rdy[2] !== 1'b0 || o_rdata[2] !== 32'h0) begin
            failures++;
            $display("FAIL reset_resp_outputs: rdy_before=%b rdy=%b rd_data=%h, want 1/0/00000000",
                     rdy_before, o_rdy[2], o_rdata[2]);
        end
        model_op(2, 0, 1, 16'h0020, 32'hABCD0123, ee, ed, kn);
        @(negedge clk);
        tb_wr[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus_op(2, 1, 0, 16'h0020, 32'h0, 0, lat, data, err, to, st, ra);
        model_op(2, 1, 0, 16'h0020, 32'h0, ee, ed, kn);
        checks++;
        if (data !== 32'hABCD0123) begin
            failures++;
            $display("FAIL reset_resp_committed: addr20=%h, want abcd0123", data);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] data; logic err, ra, ee; bit to, st, kn; logic [31:0] ed;
        int sel, hold;
        bit rd, wr;
        logic [15:0] a;
        logic [31:0] wd;
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 30; k++) begin
                sel = $urandom_range(0, 9);
                wr  = (sel <= 3) || (sel == 9);
                rd  = (sel >= 4);
                a   = ($urandom_range(0, 3) == 0) ? 16'(1020 + $urandom_range(0, 8))
                                                  : 16'($urandom_range(0, 31));
                wd  = $urandom;
                hold = $urandom_range(0, 2);
                bus_op(d, rd, wr, a, wd, hold, lat, data, err, to, st, ra);
                model_op(d, rd, wr, a, wd, ee, ed, kn);
                checks++;
                if (to || lat != wait_of(d) + 1 || err !== ee) begin
                    failures++;
                    $display("FAIL rand_resp dut%0d op%0d: timeout=%0d latency=%0d err=%b, want 0/%0d/%b",
                             d, k, to, lat, err, wait_of(d) + 1, ee);
                end
                if (kn) begin
                    checks++;
                    if (data !== ed) begin
                        failures++;
                        $display("FAIL rand_data dut%0d op%0d addr=%h: rd_data=%h, want %h",
                                 d, k, a, data, ed);
                    end
                end
                checks++;
                if (!st || ra !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_handshake dut%0d op%0d: stable=%0d rdy_after=%b, want 1/0",
                             d, k, st, ra);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tb_rd[i] = 1'b0; tb_wr[i] = 1'b0; tb_addr[i] = '0; tb_wdata[i] = '0;
            m_rd[i] = 32'h0;
            for (int j = 0; j < 1024; j++) m_kn[i][j] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_hold_stable();
        test_both_high();
        test_out_of_range();
        test_busy_change();
        test_early_drop();
        test_reset_busy();
        test_reset_resp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
